// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed-priority (highest index) or round-robin winner
// selection, with the grant held until the holder strobes rel.
module priority_arbiter_rr #(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         none
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] gntIdx_q, gntIdx_d;
  logic         gntValid_q, gntValid_d;
  logic         none_q, none_d;
  logic [W-1:0] winIdx;
  int           rrIdx;

  // Later assignments override earlier ones, so each search visits the
  // highest-priority candidate last.
  always_comb begin
    winIdx = '0;
    rrIdx  = 0;
    if (RR != 0) begin
      for (int off = N - 1; off >= 0; off--) begin
        rrIdx = int'(ptr_q) - off;
        if (rrIdx < 0) rrIdx = rrIdx + N;
        if (req[rrIdx]) winIdx = W'(rrIdx);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) winIdx = W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gntIdx_d   = gntIdx_q;
    gntValid_d = gntValid_q;
    none_d     = none_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          gntValid_d = 1'b1;
          gntIdx_d   = winIdx;
          none_d     = 1'b0;
          ptr_d      = (winIdx == '0) ? W'(N - 1) : winIdx - W'(1);
        end else begin
          none_d = 1'b1;
        end
      end
      GRANT: begin
        // Release drops the grant now; re-arbitration waits for the next edge.
        if (rel) begin
          state_d    = IDLE;
          gntValid_d = 1'b0;
          gntIdx_d   = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        gntValid_d = 1'b0;
        gntIdx_d   = '0;
        none_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= W'(N - 1);
      gntIdx_q   <= '0;
      gntValid_q <= 1'b0;
      none_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gntIdx_q   <= gntIdx_d;
      gntValid_q <= gntValid_d;
      none_q     <= none_d;
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < N; i++) begin
      gnt_onehot[i] = gntValid_q && (gntIdx_q == W'(i));
    end
  end

  assign gnt_valid = gntValid_q;
  assign gnt_idx   = gntIdx_q;
  assign none      = none_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Scoreboard bench for priority_arbiter_rr: three instances (N=4 fixed, N=4 RR, N=8 RR)
// driven one at a time; expectations are queued with the stimulus and popped after the edge.
module tb_priority_arbiter_rr;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       n;
  } exp_t;

  typedef struct packed {
    logic [7:0] r;
    logic       l;
    logic       s;
    logic       v;
    logic [2:0] k;
    logic       n;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req0, req1;
  logic [7:0] req2;
  logic       rel0, rel1, rel2, rst0, rst1, rst2;
  logic       v0, v1, v2, n0, n1, n2;
  logic [1:0] idx0, idx1;
  logic [2:0] idx2;
  logic [3:0] oh0, oh1;
  logic [7:0] oh2;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  priority_arbiter_rr #(.N(4), .RR(0)) dutFixed (
    .clk(clk), .rst(rst0), .req(req0), .rel(rel0),
    .gnt_valid(v0), .gnt_idx(idx0), .gnt_onehot(oh0), .none(n0));

  priority_arbiter_rr #(.N(4), .RR(1)) dutRr4 (
    .clk(clk), .rst(rst1), .req(req1), .rel(rel1),
    .gnt_valid(v1), .gnt_idx(idx1), .gnt_onehot(oh1), .none(n1));

  priority_arbiter_rr #(.N(8), .RR(1)) dutRr8 (
    .clk(clk), .rst(rst2), .req(req2), .rel(rel2),
    .gnt_valid(v2), .gnt_idx(idx2), .gnt_onehot(oh2), .none(n2));

  function automatic step_t gr(input logic [7:0] r, input int k);
    gr = '{r: r, l: 1'b0, s: 1'b0, v: 1'b1, k: 3'(k), n: 1'b0};
  endfunction

  function automatic step_t rl(input logic [7:0] r);
    rl = '{r: r, l: 1'b1, s: 1'b0, v: 1'b0, k: 3'd0, n: 1'b0};
  endfunction

  function automatic step_t idle(input logic l);
    idle = '{r: 8'h00, l: l, s: 1'b0, v: 1'b0, k: 3'd0, n: 1'b1};
  endfunction

  function automatic step_t rs(input logic [7:0] r, input logic l);
    rs = '{r: r, l: l, s: 1'b1, v: 1'b0, k: 3'd0, n: 1'b0};
  endfunction

  function automatic exp_t sample(input int d);
    exp_t o;
    case (d)
      0:       o = '{v: v0, idx: {1'b0, idx0}, oh: {4'h0, oh0}, n: n0};
      1:       o = '{v: v1, idx: {1'b0, idx1}, oh: {4'h0, oh1}, n: n1};
      default: o = '{v: v2, idx: idx2, oh: oh2, n: n2};
    endcase
    return o;
  endfunction

  // Drives one instance for one cycle (others idle) and queues its expected outputs.
  task automatic applyStimulus(input int d, input step_t st);
    exp_t e;
    req0 = 4'h0; rel0 = 1'b0; rst0 = 1'b0;
    req1 = 4'h0; rel1 = 1'b0; rst1 = 1'b0;
    req2 = 8'h00; rel2 = 1'b0; rst2 = 1'b0;
    case (d)
      0:       begin req0 = st.r[3:0]; rel0 = st.l; rst0 = st.s; end
      1:       begin req1 = st.r[3:0]; rel1 = st.l; rst1 = st.s; end
      default: begin req2 = st.r;      rel2 = st.l; rst2 = st.s; end
    endcase
    e.v   = st.v;
    e.idx = st.k;
    e.oh  = st.v ? (8'h01 << st.k) : 8'h00;
    e.n   = st.n;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o, e;
    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, rs(8'hFF, 1'b1));
      o = sample(d);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got %h expected %h", d, o, e);
      end
    end
  endtask

  task automatic test_fixed_priority();
    step_t st[$];
    exp_t  o, e;
    st = '{gr(8'h01, 0), rl(8'h00), gr(8'h02, 1), rl(8'h00), gr(8'h04, 2), rl(8'h00),
           gr(8'h08, 3), rl(8'h00), gr(8'h03, 1), rl(8'h00), gr(8'h07, 2), rl(8'h00),
           gr(8'h0C, 3), gr(8'h01, 3), gr(8'h00, 3), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(0, st[i]);
      o = sample(0);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL fixed step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  o, e;
    st = '{gr(8'h0F, 3), rl(8'h0F), gr(8'h0F, 3), rl(8'h0F), gr(8'h0F, 3), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(0, st[i]);
      o = sample(0);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_idle_none();
    step_t st[$];
    exp_t  o, e;
    st = '{idle(1'b0), idle(1'b1), idle(1'b0), gr(8'h02, 1), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(0, st[i]);
      o = sample(0);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL idle_none step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t st[$];
    exp_t  o, e;
    st = '{gr(8'h02, 1), rl(8'h08), gr(8'h08, 3), rs(8'h0F, 1'b1), idle(1'b0)};
    foreach (st[i]) begin
      applyStimulus(0, st[i]);
      o = sample(0);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL simultaneous step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    step_t st[$];
    exp_t  o, e;
    st = '{gr(8'h0F, 3), rl(8'h0F), gr(8'h0F, 2), rl(8'h0F), gr(8'h0F, 1), rl(8'h0F),
           gr(8'h0F, 0), rl(8'h0F), gr(8'h0F, 3), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(1, st[i]);
      o = sample(1);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL round_robin step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_rr_wide();
    step_t st[$];
    exp_t  o, e;
    st = '{gr(8'h81, 7), rl(8'h81), gr(8'h81, 0), rl(8'h81), gr(8'h81, 7), rl(8'h81),
           gr(8'h81, 0), rl(8'h81), gr(8'h81, 7), gr(8'h20, 7), gr(8'h20, 7), rl(8'h20),
           gr(8'h20, 5), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(2, st[i]);
      o = sample(2);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL rr_wide step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_midgrant();
    step_t st[$];
    exp_t  o, e;
    st = '{rs(8'h00, 1'b0), gr(8'h04, 2), rs(8'h04, 1'b0), gr(8'h0F, 3), rl(8'h00)};
    foreach (st[i]) begin
      applyStimulus(1, st[i]);
      o = sample(1);
      e = sbq.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_midgrant step %0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    req0 = 4'h0; rel0 = 1'b0; rst0 = 1'b1;
    req1 = 4'h0; rel1 = 1'b0; rst1 = 1'b1;
    req2 = 8'h00; rel2 = 1'b0; rst2 = 1'b1;
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_idle_none();
    test_simultaneous();
    test_round_robin();
    test_rr_wide();
    test_reset_midgrant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_rr.md
Name: priority_arbiter_rr

Overview:
- Parametrised, registered successor to the combinational 4-to-2 priority encoder.
- Accepts N request lines and selects one winner, either by fixed priority (highest index wins) or by round-robin.
- Holds the grant until the requester releases it.
- Sits between N requesting masters and a single shared resource; outputs the winner as a binary index plus a one-hot vector with a valid flag.

Parameters:
- N, 4, number of request inputs (N >= 2).
- W, $clog2(N), width of the binary grant index (derived; do not override).
- RR, 0, arbitration policy: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- rel  input  1  release strobe from the current grant holder; sampled only while gnt_valid = 1.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  W  binary index of the granted requester; 0 when gnt_valid = 0.
- gnt_onehot  output  N  one-hot grant; all zeros when gnt_valid = 0.
- none  output  1  registered flag: arbitration was attempted in IDLE with req == 0.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - State -> IDLE; gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0, none = 0.
  - Pointer ptr = N-1.
  - Reset overrides any state, including mid-grant; the grant is dropped at that edge.
- IDLE:
  - Each edge evaluates req.
  - If req != 0: winner k latched, state -> GRANT; at the same edge gnt_valid = 1, gnt_idx = k, gnt_onehot = (1 << k), none = 0.
  - If req == 0: stay in IDLE, none = 1.
  - Latency: req asserted before edge t gives gnt_valid high after edge t (one cycle).
  - rel is ignored in IDLE.
- GRANT:
  - Outputs are held stable regardless of changes on req, including the holder dropping its own req.
  - rel = 1 at an edge: state -> IDLE and all grant outputs cleared at that edge. Re-arbitration happens at the following edge, so there is exactly one dead cycle between grants.
  - rel = 0: remain in GRANT.
- Fixed policy (RR = 0): winner = highest set index of req (d=0011 -> 1, d=1100 -> 3). ptr is unused but still reset.
- Round-robin (RR = 1):
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1, wrapping; the first set bit wins.
  - ptr updates only when a grant is issued: ptr <= (k == 0) ? N-1 : k-1. This makes the just-granted index lowest priority next time.
  - Because ptr resets to N-1, the first RR decision matches fixed priority.
- Width rules:
  - gnt_idx is zero-extended into W bits.
  - For non-power-of-2 N, index values >= N are never produced.
  - Winner search must be a parametrised loop, not hard-coded cases.
- Invariants:
  - gnt_onehot has exactly one bit set when gnt_valid = 1, otherwise zero.
  - gnt_onehot[gnt_idx] = gnt_valid.
  - none = 1 implies gnt_valid = 0.
- Simultaneous events:
  - rel together with new req in GRANT: release takes effect; new req is considered next edge.
  - rst together with rel or req: reset wins.

Test Plan:
- N=4, RR=0: after reset, apply req = 0001, 0010, 0100, 1000, 0011, 0111, 1100, each followed by rel -> gnt_idx = 0, 1, 2, 3, 1, 2, 3 respectively, with gnt_onehot matching and gnt_valid one cycle after req.
- N=4, RR=0, hold req = 1111 and pulse rel repeatedly -> gnt_idx = 3 every time, with one dead cycle (gnt_valid = 0) between grants.
- N=4, RR=1, hold req = 1111 with a rel after each grant -> gnt_idx sequence 3, 2, 1, 0, 3; ptr wraps from 0 to N-1.
- N=8, RR=1, req = 10000001 held -> grants alternate 7, 0, 7, 0. Then change req to 00100000 while granted to 7 -> gnt_idx stays 7 until rel.
- IDLE with req = 0 -> none = 1, gnt_valid = 0; rel pulsed in IDLE -> no state change.
- Reset mid-grant: grant at idx 2 active, assert rst for one edge -> all outputs 0 next cycle. With RR=1, ptr = N-1 afterwards, so req = 1111 grants 3 first.
